// File: rtl/tetris_pkg.sv
// Shared board geometry, template codes and curtain state encoding.
// Used by the board pixel fetch pipeline and the gameover curtain FSM.
package tetris_pkg;

  localparam int BOARD_W = 10;  // cells per board row
  localparam int BOARD_H = 20;  // cell rows on the board
  localparam int CELL_PX = 16;  // cell edge length in pixels

  // Template codes understood by the downstream block renderer
  typedef enum logic [1:0] {
    TMPL_WHITE = 2'b00,
    TMPL_LIGHT = 2'b01,
    TMPL_DARK  = 2'b10,
    TMPL_BLACK = 2'b11
  } template_e;

  // Gameover curtain progress
  typedef enum logic [1:0] {
    CUR_IDLE  = 2'b00,
    CUR_SWEEP = 2'b01,
    CUR_DONE  = 2'b10
  } curtain_state_e;

  // Board RAM address of a cell: row*10 + col, built from shifts (8x + 2x)
  function automatic logic [7:0] cell_addr(input logic [4:0] row, input logic [3:0] col);
    logic [7:0] row8;
    row8 = {3'b000, row};
    return (row8 << 3) + (row8 << 1) + {4'b0000, col};
  endfunction

endpackage

// File: rtl/gameover_curtain.sv
// Gameover curtain FSM: after a gameover trigger, covers one more board row
// every FRAMES_PER_ROW frames until all rows are covered.
// Ports:
//   clk_i, rst_ni      - clock, synchronous active-low reset
//   frame_start_i      - one-cycle pulse per frame
//   gameover_trig_i    - starts the sweep (only honoured in IDLE)
//   new_game_i         - returns to IDLE from any state, wins over the trigger
//   state_o            - current curtain state
//   curtain_row_o      - number of rows currently covered while sweeping
//   curtain_done_o     - high exactly while the FSM is in DONE
module gameover_curtain
  import tetris_pkg::*;
#(
  parameter int FRAMES_PER_ROW = 4
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           frame_start_i,
  input  logic           gameover_trig_i,
  input  logic           new_game_i,
  output curtain_state_e state_o,
  output logic [4:0]     curtain_row_o,
  output logic           curtain_done_o
);

  localparam int              CNT_W    = (FRAMES_PER_ROW > 1) ? $clog2(FRAMES_PER_ROW) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMES_PER_ROW - 1);
  localparam logic [4:0]      ROW_LAST = 5'(BOARD_H - 1);

  curtain_state_e   state_q;
  logic [4:0]       row_q;
  logic [CNT_W-1:0] cnt_q;
  logic             done_q;

  // Curtain state machine; done flag is registered alongside the state so it
  // tracks DONE cycle-exactly.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= CUR_IDLE;
      row_q   <= 5'd0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else if (new_game_i) begin
      state_q <= CUR_IDLE;
      row_q   <= 5'd0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        CUR_IDLE: begin
          if (gameover_trig_i) begin
            state_q <= CUR_SWEEP;
            row_q   <= 5'd0;
            cnt_q   <= '0;
          end
        end
        CUR_SWEEP: begin
          if (frame_start_i) begin
            if (cnt_q == CNT_LAST) begin
              cnt_q <= '0;
              row_q <= row_q + 5'd1;
              // Last row just got covered
              if (row_q == ROW_LAST) begin
                state_q <= CUR_DONE;
                done_q  <= 1'b1;
              end
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        CUR_DONE: begin
          done_q <= 1'b1;
        end
        default: begin
          state_q <= CUR_IDLE;
          row_q   <= 5'd0;
          cnt_q   <= '0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign state_o        = state_q;
  assign curtain_row_o  = row_q;
  assign curtain_done_o = done_q;

endmodule

// File: rtl/board_pixel_fetch.sv
// Board pixel fetch: maps the VGA beam position onto the 10x20 board,
// addresses the board RAM, and delivers the cell template, in-cell pixel
// offset and curtain coverage two cycles after the pixel is presented.
// Ports:
//   Clk, Reset_n                 - clock, synchronous active-low reset
//   DrawX, DrawY, in_valid       - beam position and its qualifier
//   frame_start, gameover_trig,
//   new_game                     - curtain control pulses
//   ram_addr / ram_data          - board RAM (1-cycle read latency)
//   block_template, pixel_x,
//   pixel_y, gameover, out_valid - per-pixel results, latency 2
//   curtain_done                 - curtain fully drawn
module board_pixel_fetch
  import tetris_pkg::*;
#(
  parameter int BOARD_X0       = 240,
  parameter int BOARD_Y0       = 80,
  parameter int FRAMES_PER_ROW = 4
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  input  logic       in_valid,
  input  logic       frame_start,
  input  logic       gameover_trig,
  input  logic       new_game,
  output logic [7:0] ram_addr,
  input  logic [1:0] ram_data,
  output logic [1:0] block_template,
  output logic [3:0] pixel_x,
  output logic [3:0] pixel_y,
  output logic       gameover,
  output logic       out_valid,
  output logic       curtain_done
);

  localparam logic [9:0] X_LO = 10'(BOARD_X0);
  localparam logic [9:0] X_HI = 10'(BOARD_X0 + BOARD_W * CELL_PX);
  localparam logic [9:0] Y_LO = 10'(BOARD_Y0);
  localparam logic [9:0] Y_HI = 10'(BOARD_Y0 + BOARD_H * CELL_PX);

  curtain_state_e cur_state_s;
  logic [4:0]     cur_row_s;

  gameover_curtain #(
    .FRAMES_PER_ROW(FRAMES_PER_ROW)
  ) u_curtain (
    .clk_i          (Clk),
    .rst_ni         (Reset_n),
    .frame_start_i  (frame_start),
    .gameover_trig_i(gameover_trig),
    .new_game_i     (new_game),
    .state_o        (cur_state_s),
    .curtain_row_o  (cur_row_s),
    .curtain_done_o (curtain_done)
  );

  // Pixel offsets relative to the board origin; only the in-board range is
  // meaningful, so the offsets are truncated to what the board can span.
  logic [7:0] dx_s;
  logic [8:0] dy_s;
  logic       in_board_s;
  logic [3:0] col_s;
  logic [4:0] row_s;

  // Board geometry decode and RAM address generation
  always_comb begin
    dx_s       = 8'(DrawX - X_LO);
    dy_s       = 9'(DrawY - Y_LO);
    in_board_s = (DrawX >= X_LO) && (DrawX < X_HI) && (DrawY >= Y_LO) && (DrawY < Y_HI);
    col_s      = dx_s[7:4];
    row_s      = dy_s[8:4];
    if (in_board_s) begin
      ram_addr = cell_addr(row_s, col_s);
    end else begin
      ram_addr = 8'd0;
    end
  end

  // Stage 1 state: pixel geometry plus a snapshot of the curtain, so the
  // coverage decision for a pixel never sees a curtain step half-way.
  logic [3:0] col_q;
  logic [4:0] row_q;
  logic [3:0] px_q;
  logic [3:0] py_q;
  logic       inb_q;
  logic       vld1_q;
  logic       sweep_q;
  logic       cdone_q;
  logic [4:0] crow_q;

  // Stage 1 registers
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      col_q   <= 4'd0;
      row_q   <= 5'd0;
      px_q    <= 4'd0;
      py_q    <= 4'd0;
      inb_q   <= 1'b0;
      vld1_q  <= 1'b0;
      sweep_q <= 1'b0;
      cdone_q <= 1'b0;
      crow_q  <= 5'd0;
    end else begin
      col_q   <= col_s;
      row_q   <= row_s;
      px_q    <= dx_s[3:0];
      py_q    <= dy_s[3:0];
      inb_q   <= in_board_s;
      vld1_q  <= in_valid;
      sweep_q <= (cur_state_s == CUR_SWEEP);
      cdone_q <= (cur_state_s == CUR_DONE);
      crow_q  <= cur_row_s;
    end
  end

  // Defensive re-check of the cell coordinates on top of the in-board flag
  logic       cell_ok_s;
  logic [1:0] tmpl_d;
  logic [3:0] px_d;
  logic [3:0] py_d;
  logic       go_d;

  // Stage 2 next-state: template select, offset masking, curtain coverage
  always_comb begin
    cell_ok_s = inb_q && (col_q < 4'(BOARD_W)) && (row_q < 5'(BOARD_H));
    tmpl_d    = TMPL_BLACK;
    px_d      = 4'd0;
    py_d      = 4'd0;
    go_d      = 1'b0;
    if (cell_ok_s) begin
      tmpl_d = ram_data;
      px_d   = px_q;
      py_d   = py_q;
      go_d   = (sweep_q && (row_q < crow_q)) || cdone_q;
    end else begin
      tmpl_d = TMPL_BLACK;
      px_d   = 4'd0;
      py_d   = 4'd0;
      go_d   = 1'b0;
    end
  end

  logic [1:0] tmpl_q;
  logic [3:0] pxo_q;
  logic [3:0] pyo_q;
  logic       go_q;
  logic       vld2_q;

  // Stage 2 registers (module outputs)
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      tmpl_q <= TMPL_BLACK;
      pxo_q  <= 4'd0;
      pyo_q  <= 4'd0;
      go_q   <= 1'b0;
      vld2_q <= 1'b0;
    end else begin
      tmpl_q <= tmpl_d;
      pxo_q  <= px_d;
      pyo_q  <= py_d;
      go_q   <= go_d;
      vld2_q <= vld1_q;
    end
  end

  assign block_template = tmpl_q;
  assign pixel_x        = pxo_q;
  assign pixel_y        = pyo_q;
  assign gameover       = go_q;
  assign out_valid      = vld2_q;

endmodule

// File: tb/tb_board_pixel_fetch.sv
// Directed self-checking bench for board_pixel_fetch. The board RAM is
// modelled as a synchronous read memory holding mem[a] = a[1:0] ^ 2'b01, and
// all expected values below are worked out by hand from that pattern.
module tb_board_pixel_fetch;

  logic       Clk;
  logic       Reset_n;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       in_valid;
  logic       frame_start;
  logic       gameover_trig;
  logic       new_game;
  logic [7:0] ram_addr;
  logic [1:0] ram_data;
  logic [1:0] block_template;
  logic [3:0] pixel_x;
  logic [3:0] pixel_y;
  logic       gameover;
  logic       out_valid;
  logic       curtain_done;

  logic [1:0] mem [256];
  int vectors;
  int miscompares;

  board_pixel_fetch #(
    .BOARD_X0(240),
    .BOARD_Y0(80),
    .FRAMES_PER_ROW(4)
  ) dut (
    .Clk(Clk),
    .Reset_n(Reset_n),
    .DrawX(DrawX),
    .DrawY(DrawY),
    .in_valid(in_valid),
    .frame_start(frame_start),
    .gameover_trig(gameover_trig),
    .new_game(new_game),
    .ram_addr(ram_addr),
    .ram_data(ram_data),
    .block_template(block_template),
    .pixel_x(pixel_x),
    .pixel_y(pixel_y),
    .gameover(gameover),
    .out_valid(out_valid),
    .curtain_done(curtain_done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Board RAM model: one-cycle read latency
  always @(posedge Clk) ram_data <= mem[ram_addr];

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
  endtask

  // Present one pixel for a single cycle and check address, latency and results
  task automatic pix(input string tag, input logic [9:0] x, input logic [9:0] y,
                     input logic [7:0] e_addr, input logic [1:0] e_tmpl,
                     input logic [3:0] e_px, input logic [3:0] e_py, input logic e_go);
    DrawX    = x;
    DrawY    = y;
    in_valid = 1'b1;
    #1;
    chk({tag, ".addr"}, 32'(ram_addr), 32'(e_addr));
    tick();
    in_valid = 1'b0;
    chk({tag, ".early_valid"}, 32'(out_valid), 32'd0);
    tick();
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".tmpl"}, 32'(block_template), 32'(e_tmpl));
    chk({tag, ".px"}, 32'(pixel_x), 32'(e_px));
    chk({tag, ".py"}, 32'(pixel_y), 32'(e_py));
    chk({tag, ".go"}, 32'(gameover), 32'(e_go));
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 2'(i) ^ 2'b01;
    end
    Reset_n       = 1'b0;
    DrawX         = 10'd0;
    DrawY         = 10'd0;
    in_valid      = 1'b0;
    frame_start   = 1'b0;
    gameover_trig = 1'b0;
    new_game      = 1'b0;

    // Reset state
    tick(); tick(); tick();
    chk("rst.valid", 32'(out_valid), 32'd0);
    chk("rst.tmpl", 32'(block_template), 32'd3);
    chk("rst.px", 32'(pixel_x), 32'd0);
    chk("rst.py", 32'(pixel_y), 32'd0);
    chk("rst.go", 32'(gameover), 32'd0);
    chk("rst.done", 32'(curtain_done), 32'd0);
    Reset_n = 1'b1;
    tick();

    // Geometry and template fetch
    pix("origin", 10'd240, 10'd80, 8'd0, 2'b01, 4'd0, 4'd0, 1'b0);
    pix("mid", 10'd275, 10'd130, 8'd32, 2'b01, 4'd3, 4'd2, 1'b0);
    pix("last", 10'd399, 10'd399, 8'd199, 2'b10, 4'd15, 4'd15, 1'b0);
    pix("right_out", 10'd400, 10'd399, 8'd0, 2'b11, 4'd0, 4'd0, 1'b0);
    pix("left_out", 10'd239, 10'd80, 8'd0, 2'b11, 4'd0, 4'd0, 1'b0);
    pix("bottom_out", 10'd240, 10'd400, 8'd0, 2'b11, 4'd0, 4'd0, 1'b0);

    // Curtain sweep with a retrigger that must be ignored
    gameover_trig = 1'b1;
    tick();
    gameover_trig = 1'b0;
    chk("sweep.done0", 32'(curtain_done), 32'd0);
    pix("sweep.row0_start", 10'd250, 10'd80, 8'd0, 2'b01, 4'd10, 4'd0, 1'b0);
    for (int i = 0; i < 4; i++) frame();
    gameover_trig = 1'b1;
    tick();
    gameover_trig = 1'b0;
    for (int i = 0; i < 4; i++) frame();
    pix("sweep.row1", 10'd250, 10'd96, 8'd10, 2'b11, 4'd10, 4'd0, 1'b1);
    pix("sweep.row2", 10'd250, 10'd112, 8'd20, 2'b01, 4'd10, 4'd0, 1'b0);
    pix("sweep.row0", 10'd250, 10'd80, 8'd0, 2'b01, 4'd10, 4'd0, 1'b1);
    pix("sweep.outside", 10'd100, 10'd100, 8'd0, 2'b11, 4'd0, 4'd0, 1'b0);

    // 79 pulses in total: row 19 still uncovered
    for (int i = 0; i < 71; i++) frame();
    chk("sweep.done79", 32'(curtain_done), 32'd0);
    pix("sweep.row19", 10'd399, 10'd399, 8'd199, 2'b10, 4'd15, 4'd15, 1'b0);
    frame();
    chk("done.flag", 32'(curtain_done), 32'd1);
    pix("done.last", 10'd399, 10'd399, 8'd199, 2'b10, 4'd15, 4'd15, 1'b1);
    pix("done.origin", 10'd240, 10'd80, 8'd0, 2'b01, 4'd0, 4'd0, 1'b1);
    pix("done.outside", 10'd400, 10'd399, 8'd0, 2'b11, 4'd0, 4'd0, 1'b0);

    // new_game wins over a simultaneous trigger
    gameover_trig = 1'b1;
    new_game      = 1'b1;
    tick();
    gameover_trig = 1'b0;
    new_game      = 1'b0;
    chk("newgame.done", 32'(curtain_done), 32'd0);
    for (int i = 0; i < 4; i++) frame();
    pix("newgame.row0", 10'd240, 10'd80, 8'd0, 2'b01, 4'd0, 4'd0, 1'b0);

    // Reset in the middle of a sweep with a running pixel stream
    gameover_trig = 1'b1;
    tick();
    gameover_trig = 1'b0;
    for (int i = 0; i < 8; i++) frame();
    DrawX    = 10'd250;
    DrawY    = 10'd96;
    in_valid = 1'b1;
    Reset_n  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("midrst.valid", 32'(out_valid), 32'd0);
      chk("midrst.tmpl", 32'(block_template), 32'd3);
      chk("midrst.px", 32'(pixel_x), 32'd0);
      chk("midrst.go", 32'(gameover), 32'd0);
      chk("midrst.done", 32'(curtain_done), 32'd0);
    end
    Reset_n = 1'b1;
    tick();
    chk("release.valid1", 32'(out_valid), 32'd0);
    tick();
    chk("release.valid2", 32'(out_valid), 32'd1);
    chk("release.tmpl", 32'(block_template), 32'd3);
    chk("release.px", 32'(pixel_x), 32'd10);
    chk("release.py", 32'(pixel_y), 32'd0);
    chk("release.go", 32'(gameover), 32'd0);
    in_valid = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/board_pixel_fetch.md
BOARD_PIXEL_FETCH -- requirements
Module: board_pixel_fetch

Interface
Parameters:
REQ-001 SHALL have parameter BOARD_X0, default 240: screen X of the board's left edge.
REQ-002 SHALL have parameter BOARD_Y0, default 80: screen Y of the board's top edge.
REQ-003 SHALL have parameter FRAMES_PER_ROW, default 4: frames per curtain row step.

Ports:
REQ-004 SHALL have port Clk, input, 1 bit: single clock.
REQ-005 SHALL have port Reset_n, input, 1 bit: reset, synchronous, active-low.
REQ-006 SHALL have port DrawX, input, 10 bits: current VGA pixel column.
REQ-007 SHALL have port DrawY, input, 10 bits: current VGA pixel row.
REQ-008 SHALL have port in_valid, input, 1 bit: DrawX/DrawY are valid this cycle.
REQ-009 SHALL have port frame_start, input, 1 bit: one-cycle pulse at each frame start.
REQ-010 SHALL have port gameover_trig, input, 1 bit: one-cycle pulse that starts the gameover curtain.
REQ-011 SHALL have port new_game, input, 1 bit: one-cycle pulse that clears the curtain.
REQ-012 SHALL have port ram_addr, output, 8 bits: board RAM address, row*10+col.
REQ-013 SHALL have port ram_data, input, 2 bits: board RAM template code, valid 1 cycle after ram_addr.
REQ-014 SHALL have port block_template, output, 2 bits: template code for the downstream block renderer.
REQ-015 SHALL have port pixel_x, output, 4 bits: pixel offset inside the cell, horizontal.
REQ-016 SHALL have port pixel_y, output, 4 bits: pixel offset inside the cell, vertical.
REQ-017 SHALL have port gameover, output, 1 bit: this pixel's cell is covered by the curtain.
REQ-018 SHALL have port out_valid, output, 1 bit: outputs correspond to a valid input pixel.
REQ-019 SHALL have port curtain_done, output, 1 bit: the curtain has covered all 20 rows.

Function
REQ-020 SHALL treat the board as 10 columns x 20 rows of 16x16-pixel cells.
REQ-021 SHALL treat a pixel as in-board when BOARD_X0 <= DrawX < BOARD_X0+160 and BOARD_Y0 <= DrawY < BOARD_Y0+320.
REQ-022 SHALL compute col = (DrawX-BOARD_X0)>>4 (4 bits), row = (DrawY-BOARD_Y0)>>4 (5 bits), pixel_x = (DrawX-BOARD_X0)[3:0], pixel_y = (DrawY-BOARD_Y0)[3:0].
REQ-023 SHALL drive ram_addr combinationally from DrawX/DrawY as row*10+col, range 0..199, when in-board; out-of-board it SHALL drive 0.
REQ-024 SHALL be a 2-stage pipeline with latency 2: inputs sampled at edge N produce outputs at edge N+2, one pixel per cycle, no stalls.
REQ-025 Stage 1 SHALL register col, row, pixel_x, pixel_y, in-board flag, and in_valid.
REQ-026 Stage 2 SHALL register block_template = ram_data when in-board, else 2'b11 (black).
REQ-027 SHALL output pixel_x = pixel_y = 0 and gameover = 0 for out-of-board pixels.
REQ-028 SHALL pipeline out_valid from in_valid; the other outputs are don't-care while out_valid = 0.
REQ-029 The curtain FSM SHALL have states IDLE, SWEEP, DONE, with curtain_row (5 bits) and frame_cnt (width for FRAMES_PER_ROW).
REQ-030 In IDLE, gameover_trig SHALL move the FSM to SWEEP with curtain_row = 0 and frame_cnt = 0.
REQ-031 In SWEEP, each frame_start SHALL increment frame_cnt; at FRAMES_PER_ROW-1 it SHALL wrap to 0 and increment curtain_row.
REQ-032 When curtain_row reaches 20, the FSM SHALL move to DONE.
REQ-033 In DONE, curtain_done SHALL be 1; it SHALL be 0 in all other states.
REQ-034 new_game in any state SHALL return the FSM to IDLE and clear curtain_row and frame_cnt.
REQ-035 new_game SHALL win over a simultaneous gameover_trig.
REQ-036 gameover_trig outside IDLE SHALL be ignored.
REQ-037 In-board gameover SHALL be 1 when (state = SWEEP and row < curtain_row) or state = DONE, and 0 in IDLE.
REQ-038 gameover SHALL use the curtain state sampled in stage 1, so a curtain step is never visible mid-pixel.

Reset
REQ-039 While Reset_n = 0 at a Clk edge, all pipeline registers SHALL clear.
REQ-040 Outputs during reset SHALL be: out_valid = 0, block_template = 2'b11, pixel_x = pixel_y = 0, gameover = 0, curtain_done = 0.
REQ-041 Reset SHALL put the FSM in IDLE with curtain_row = 0 and frame_cnt = 0.
REQ-042 Reset during SWEEP SHALL abort the sweep; the first valid output after release SHALL appear 2 cycles after the first valid input.

Structure
REQ-043 Shared package tetris_pkg SHALL hold BOARD_W = 10, BOARD_H = 20, CELL_PX = 16, the template codes (WHITE 00, LIGHT 01, DARK 10, BLACK 11), and the curtain state enum.
REQ-044 The curtain FSM SHALL be a sub-module named gameover_curtain; the pixel pipeline stays in the top module.

Verification
REQ-045 Scenario: DrawX = 240, DrawY = 80, ram_data = 01 -> ram_addr = 0; two cycles later block_template = 01, pixel_x = 0, pixel_y = 0, out_valid = 1.
REQ-046 Scenario: DrawX = 399, DrawY = 399 -> ram_addr = 199, pixel_x = 15, pixel_y = 15; DrawX = 400 -> block_template = 11, gameover = 0.
REQ-047 Scenario: gameover_trig, then 8 frame_start pulses (FRAMES_PER_ROW = 4) -> curtain_row = 2; row 1 pixels gameover = 1, row 2 pixels gameover = 0.
REQ-048 Scenario: 80 frame_start pulses after gameover_trig -> curtain_done = 1 and every in-board pixel gameover = 1.
REQ-049 Scenario: gameover_trig and new_game in the same cycle during DONE -> IDLE, curtain_done = 0 next cycle.
REQ-050 Scenario: Reset_n = 0 mid-SWEEP with a stream of in_valid -> out_valid = 0 throughout reset; after release gameover = 0 and output resumes with latency 2.
